// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared ALU hookup and the response buffer.
// slave is the arbiter side; master is the requester/ALU/consumer side.
interface alu_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned UOP_W  = 5
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_lhs;
    logic [DATA_W-1:0] req0_rhs;
    logic [UOP_W-1:0]  req0_uop;
    logic              req0_setflags;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_lhs;
    logic [DATA_W-1:0] req1_rhs;
    logic [UOP_W-1:0]  req1_uop;
    logic              req1_setflags;

    logic [DATA_W-1:0] alu_lhs;
    logic [DATA_W-1:0] alu_rhs;
    logic [UOP_W-1:0]  alu_uop;
    logic [DATA_W-1:0] alu_out;
    logic [3:0]        alu_flags;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic [3:0]        rsp_flags;
    logic              rsp_err;

    logic [3:0]        flags_q;

    modport slave (
        input  req0_valid, req0_lhs, req0_rhs, req0_uop, req0_setflags,
        input  req1_valid, req1_lhs, req1_rhs, req1_uop, req1_setflags,
        input  alu_out, alu_flags, rsp_ready,
        output req0_ready, req1_ready,
        output alu_lhs, alu_rhs, alu_uop,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, flags_q
    );

    modport master (
        output req0_valid, req0_lhs, req0_rhs, req0_uop, req0_setflags,
        output req1_valid, req1_lhs, req1_rhs, req1_uop, req1_setflags,
        output alu_out, alu_flags, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_lhs, alu_rhs, alu_uop,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, flags_q
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational ALU, with a
// one-entry registered response buffer and the architectural flag register.
module alu_arbiter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned UOP_W   = 5,
    parameter int unsigned MAX_UOP = 8
) (
    input logic         clk,
    input logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam logic [UOP_W-1:0] UopNop = '0;
    localparam logic [UOP_W-1:0] UopCmp = UOP_W'(5);
    localparam logic [UOP_W-1:0] UopMax = UOP_W'(MAX_UOP);

    logic              can_accept;
    logic              gnt0;
    logic              gnt1;
    logic              accept;
    logic [DATA_W-1:0] sel_lhs;
    logic [DATA_W-1:0] sel_rhs;
    logic [UOP_W-1:0]  sel_uop;
    logic              sel_setflags;
    logic              illegal;

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]        rsp_flags_q, rsp_flags_d;
    logic              rsp_err_q, rsp_err_d;
    logic              last_grant_q, last_grant_d;
    logic [3:0]        arch_flags_q, arch_flags_d;

    assign can_accept = !rsp_valid_q || bus.rsp_ready;

    // Round-robin grant: contention goes to the port that did not win last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (can_accept) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    assign accept = gnt0 || gnt1;

    // Steer the granted operands to the ALU; idle and illegal ops issue a zeroed NOP.
    always_comb begin
        sel_lhs      = gnt1 ? bus.req1_lhs      : bus.req0_lhs;
        sel_rhs      = gnt1 ? bus.req1_rhs      : bus.req0_rhs;
        sel_uop      = gnt1 ? bus.req1_uop      : bus.req0_uop;
        sel_setflags = gnt1 ? bus.req1_setflags : bus.req0_setflags;
        illegal      = sel_uop > UopMax;
        bus.alu_lhs  = '0;
        bus.alu_rhs  = '0;
        bus.alu_uop  = UopNop;
        if (accept && !illegal) begin
            bus.alu_lhs = sel_lhs;
            bus.alu_rhs = sel_rhs;
            bus.alu_uop = sel_uop;
        end
    end

    // Response buffer and flag register next state.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        last_grant_d = last_grant_q;
        arch_flags_d = arch_flags_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = gnt1;
            last_grant_d = gnt1;
            if (illegal) begin
                rsp_result_d = '0;
                rsp_flags_d  = '0;
                rsp_err_d    = 1'b1;
            end else begin
                rsp_result_d = bus.alu_out;
                rsp_flags_d  = bus.alu_flags;
                rsp_err_d    = 1'b0;
                // NOP never touches the flags, even when setflags is asserted.
                if (sel_uop != UopNop && (sel_setflags || sel_uop == UopCmp)) begin
                    arch_flags_d = bus.alu_flags;
                end
            end
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers; last_grant resets to 1 so port 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
            last_grant_q <= 1'b1;
            arch_flags_q <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            last_grant_q <= last_grant_d;
            arch_flags_q <= arch_flags_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.flags_q    = arch_flags_q;
endmodule
